// File: rtl/lcd_cmd_pkg.sv
// Shared opcodes, decoder states and power-on defaults for the SPI LCD command subset.
// Used by the responder, the panel driver and the bench so all agree on encodings.
package lcd_cmd_pkg;

  // Minimum clk periods per lcd_clk period that the receiver samples correctly.
  localparam int CLK_DIV_MIN = 4;

  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_INVOFF  = 8'h20;
  localparam logic [7:0] OP_INVON   = 8'h21;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  localparam logic [15:0] DEF_XS = 16'h0000;
  localparam logic [15:0] DEF_XE = 16'h00EF;
  localparam logic [15:0] DEF_YS = 16'h0000;
  localparam logic [15:0] DEF_YE = 16'h013F;

  localparam logic [7:0] DEF_MADCTL = 8'h00;
  localparam logic [7:0] DEF_COLMOD = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_PARAM = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_e;

endpackage

// File: rtl/lcd_spi_deser.sv
// Synchronizes the SPI pins, detects lcd_clk rising edges while selected and shifts
// bytes MSB first; a CS rise with a partial byte pending reports an abort.
module lcd_spi_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_lcd_clk,
  input  logic       i_lcd_cs,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_data,
  output logic       o_done,
  output logic [7:0] o_byte,
  output logic       o_is_data,
  output logic       o_abort
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_cs_sync;
  logic [1:0] r_rs_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_d;
  logic       r_cs_d;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;

  logic w_clk;
  logic w_cs;
  logic w_rs;
  logic w_data;
  logic w_rise;
  logic w_cs_rise;

  assign w_clk     = r_clk_sync[1];
  assign w_cs      = r_cs_sync[1];
  assign w_rs      = r_rs_sync[1];
  assign w_data    = r_data_sync[1];
  assign w_rise    = w_clk & ~r_clk_d & ~w_cs;
  assign w_cs_rise = w_cs & ~r_cs_d;

  // CS syncs reset high so leaving reset never looks like a deselect edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_rs_sync   <= 2'b00;
      r_data_sync <= 2'b00;
      r_clk_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_lcd_clk};
      r_cs_sync   <= {r_cs_sync[0], i_lcd_cs};
      r_rs_sync   <= {r_rs_sync[0], i_lcd_rs};
      r_data_sync <= {r_data_sync[0], i_lcd_data};
      r_clk_d     <= w_clk;
      r_cs_d      <= w_cs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
      o_done    <= 1'b0;
      o_byte    <= 8'h00;
      o_is_data <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      if (w_cs) begin
        r_bit_cnt <= 3'd0;
        o_abort   <= w_cs_rise && (r_bit_cnt != 3'd0);
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {r_shift[5:0], w_data};
        if (r_bit_cnt == 3'd7) begin
          o_done    <= 1'b1;
          o_byte    <= {r_shift, w_data};
          o_is_data <= w_rs;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_responder.sv
// Panel-side model of the write-only SPI LCD link: decodes the command subset into
// register state and turns RAMWR data into addressed RGB565 pixel writes.
import lcd_cmd_pkg::*;

module lcd_spi_responder #(
  parameter int MAX_PARAMS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_clk,
  input  logic        lcd_cs,
  input  logic        lcd_rs,
  input  logic        lcd_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pixel_valid,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [15:0] pixel_rgb,
  output logic        frame_done,
  output logic        sleep_out,
  output logic        display_on,
  output logic        inv_on,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod,
  output logic        abort,
  output logic [1:0]  dbg_state
);

  localparam int IW = $clog2(MAX_PARAMS + 1);
  localparam logic [IW-1:0] MAXP = IW'(MAX_PARAMS);

  // byte_valid, pixel_valid, frame_done and abort are single-cycle valid strobes with
  // no ready: the link cannot be stalled, so consumers must take them when they fire.
  logic       w_done;
  logic [7:0] w_byte;
  logic       w_is_data;
  logic       w_abort;

  lcd_spi_deser u_deser (
    .clk        (clk),
    .reset      (reset),
    .i_lcd_clk  (lcd_clk),
    .i_lcd_cs   (lcd_cs),
    .i_lcd_rs   (lcd_rs),
    .i_lcd_data (lcd_data),
    .o_done     (w_done),
    .o_byte     (w_byte),
    .o_is_data  (w_is_data),
    .o_abort    (w_abort)
  );

  dec_state_e    r_state;
  dec_state_e    w_next;
  dec_state_e    w_mode;
  logic [7:0]    r_opcode;
  logic [IW-1:0] r_param_idx;
  logic [7:0]    r_p0;
  logic [7:0]    r_p1;
  logic [7:0]    r_p2;
  logic [15:0]   r_xs;
  logic [15:0]   r_xe;
  logic [15:0]   r_ys;
  logic [15:0]   r_ye;
  logic [15:0]   r_x;
  logic [15:0]   r_y;
  logic          r_phase;
  logic [7:0]    r_hi;

  logic w_cmd_byte;
  logic w_param_byte;
  logic w_pix_byte;
  logic w_x_wrap;
  logic w_y_wrap;

  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // CMD lasts one cycle; CS edges never end a command since parameters may span frames.
  always_comb begin
    w_next = r_state;
    if (w_done && !w_is_data)  w_next = ST_CMD;
    else if (r_state == ST_CMD) w_next = (r_opcode == OP_RAMWR) ? ST_RAMWR : ST_PARAM;
  end

  always_comb begin
    w_mode = r_state;
    if (r_state == ST_CMD) w_mode = (r_opcode == OP_RAMWR) ? ST_RAMWR : ST_PARAM;
    w_cmd_byte   = w_done && !w_is_data;
    w_param_byte = w_done && w_is_data && (w_mode == ST_PARAM) && (r_param_idx < MAXP);
    w_pix_byte   = w_done && w_is_data && (w_mode == ST_RAMWR);
    w_x_wrap     = (r_x == r_xe);
    w_y_wrap     = (r_y == r_ye);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_x      <= 16'h0000;
      pixel_y      <= 16'h0000;
      pixel_rgb    <= 16'h0000;
      frame_done   <= 1'b0;
      sleep_out    <= 1'b0;
      display_on   <= 1'b0;
      inv_on       <= 1'b0;
      madctl       <= DEF_MADCTL;
      colmod       <= DEF_COLMOD;
      abort        <= 1'b0;
      r_opcode     <= 8'h00;
      r_param_idx  <= '0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_xs         <= DEF_XS;
      r_xe         <= DEF_XE;
      r_ys         <= DEF_YS;
      r_ye         <= DEF_YE;
      r_x          <= DEF_XS;
      r_y          <= DEF_YS;
      r_phase      <= 1'b0;
      r_hi         <= 8'h00;
    end else begin
      byte_valid  <= w_done;
      abort       <= w_abort;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (w_done) begin
        byte_data    <= w_byte;
        byte_is_data <= w_is_data;
      end

      // A new command also drops any half-received pixel.
      if (w_cmd_byte) begin
        r_opcode    <= w_byte;
        r_param_idx <= '0;
        r_phase     <= 1'b0;
        case (w_byte)
          OP_SLPIN:   sleep_out  <= 1'b0;
          OP_SLPOUT:  sleep_out  <= 1'b1;
          OP_INVOFF:  inv_on     <= 1'b0;
          OP_INVON:   inv_on     <= 1'b1;
          OP_DISPOFF: display_on <= 1'b0;
          OP_DISPON:  display_on <= 1'b1;
          OP_RAMWR: begin
            r_x <= r_xs;
            r_y <= r_ys;
          end
          default: ;
        endcase
      end

      if (w_param_byte) begin
        r_param_idx <= r_param_idx + IW'(1);
        case (r_param_idx)
          IW'(0):  r_p0 <= w_byte;
          IW'(1):  r_p1 <= w_byte;
          IW'(2):  r_p2 <= w_byte;
          default: ;
        endcase
        case (r_opcode)
          OP_CASET: if (r_param_idx == IW'(3)) begin
            r_xs <= {r_p0, r_p1};
            r_xe <= {r_p2, w_byte};
          end
          OP_RASET: if (r_param_idx == IW'(3)) begin
            r_ys <= {r_p0, r_p1};
            r_ye <= {r_p2, w_byte};
          end
          OP_MADCTL: if (r_param_idx == IW'(0)) madctl <= w_byte;
          OP_COLMOD: if (r_param_idx == IW'(0)) colmod <= w_byte;
          default: ;
        endcase
      end

      if (w_pix_byte) begin
        if (!r_phase) begin
          r_hi    <= w_byte;
          r_phase <= 1'b1;
        end else begin
          r_phase     <= 1'b0;
          pixel_valid <= 1'b1;
          pixel_x     <= r_x;
          pixel_y     <= r_y;
          pixel_rgb   <= {r_hi, w_byte};
          if (w_x_wrap) begin
            r_x <= r_xs;
            if (w_y_wrap) begin
              r_y        <= r_ys;
              frame_done <= 1'b1;
            end else begin
              r_y <= r_y + 16'd1;
            end
          end else begin
            r_x <= r_x + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_responder.sv
// Directed bench for lcd_spi_responder: bit-bangs the SPI link and checks decoded
// bytes, register state, pixel addresses, frame wrap and abort behaviour.
module tb_lcd_spi_responder;
  import lcd_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lcd_clk = 1'b1;
  logic        lcd_cs = 1'b1;
  logic        lcd_rs = 1'b0;
  logic        lcd_data = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_data;
  logic        pixel_valid;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic [15:0] pixel_rgb;
  logic        frame_done;
  logic        sleep_out;
  logic        display_on;
  logic        inv_on;
  logic [7:0]  madctl;
  logic [7:0]  colmod;
  logic        abort;
  logic [1:0]  dbg_state;

  lcd_spi_responder #(.MAX_PARAMS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .lcd_clk      (lcd_clk),
    .lcd_cs       (lcd_cs),
    .lcd_rs       (lcd_rs),
    .lcd_data     (lcd_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .pixel_valid  (pixel_valid),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_rgb    (pixel_rgb),
    .frame_done   (frame_done),
    .sleep_out    (sleep_out),
    .display_on   (display_on),
    .inv_on       (inv_on),
    .madctl       (madctl),
    .colmod       (colmod),
    .abort        (abort),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_q[$];
  logic [8:0]  got_bytes[$];
  logic [48:0] exp_pix[$];
  logic [48:0] got_pix[$];
  int          abort_cnt = 0;
  int unsigned last_bv_cyc = 0;
  int unsigned last_rise_cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (byte_valid) begin
      got_bytes.push_back({byte_is_data, byte_data});
      last_bv_cyc = cyc;
    end
    if (pixel_valid) got_pix.push_back({frame_done, pixel_x, pixel_y, pixel_rgb});
    if (abort) abort_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic rs, input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      lcd_rs   = rs;
      lcd_data = b[i];
      lcd_clk  = 1'b0;
      wait_clks(CLK_DIV_MIN);
      lcd_clk  = 1'b1;
      last_rise_cyc = cyc;
      wait_clks(CLK_DIV_MIN);
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_bits(rs, b, 8);
  endtask

  task automatic cs_low();
    lcd_cs = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high();
    lcd_cs = 1'b1;
    wait_clks(8);
  endtask

  task automatic clear_obs();
    got_bytes.delete();
    got_pix.delete();
    exp_q.delete();
    exp_pix.delete();
    abort_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(8);
    n_checks++;
    if ({byte_valid, pixel_valid, frame_done, abort} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {byte_valid, pixel_valid, frame_done, abort});
    else n_pass++;
    n_checks++;
    if ({sleep_out, display_on, inv_on} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {sleep_out, display_on, inv_on});
    else n_pass++;
    n_checks++;
    if (madctl !== 8'h00) $display("FAIL reset_madctl got %02h want 00", madctl);
    else n_pass++;
    n_checks++;
    if (colmod !== 8'h66) $display("FAIL reset_colmod got %02h want 66", colmod);
    else n_pass++;
    n_checks++;
    if ({pixel_x, pixel_y, pixel_rgb, byte_data} !== 56'h0)
      $display("FAIL reset_data got %014h want 0", {pixel_x, pixel_y, pixel_rgb, byte_data});
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state);
    else n_pass++;
    n_checks++;
    if (got_bytes.size() != 0 || abort_cnt != 0)
      $display("FAIL reset_no_events got bytes=%0d aborts=%0d want 0/0", got_bytes.size(), abort_cnt);
    else n_pass++;
  endtask

  task automatic test_commands();
    logic [8:0] exp_b;
    logic [8:0] got_b;
    clear_obs();
    cs_low();
    send_byte(1'b0, 8'h11); exp_q.push_back({1'b0, 8'h11});
    send_byte(1'b0, 8'h29); exp_q.push_back({1'b0, 8'h29});
    wait_clks(6);
    n_checks++;
    if (last_bv_cyc - last_rise_cyc != 4)
      $display("FAIL byte_latency got %0d want 4", last_bv_cyc - last_rise_cyc);
    else n_pass++;
    n_checks++;
    if ({sleep_out, display_on} !== 2'b11)
      $display("FAIL slpout_dispon got %b want 11", {sleep_out, display_on});
    else n_pass++;
    send_byte(1'b0, 8'h21); exp_q.push_back({1'b0, 8'h21});
    send_byte(1'b0, 8'h36); exp_q.push_back({1'b0, 8'h36});
    send_byte(1'b1, 8'h48); exp_q.push_back({1'b1, 8'h48});
    send_byte(1'b0, 8'h3A); exp_q.push_back({1'b0, 8'h3A});
    send_byte(1'b1, 8'h55); exp_q.push_back({1'b1, 8'h55});
    send_byte(1'b1, 8'h99); exp_q.push_back({1'b1, 8'h99});
    wait_clks(6);
    n_checks++;
    if ({inv_on, madctl, colmod} !== {1'b1, 8'h48, 8'h55})
      $display("FAIL config_regs got inv=%b madctl=%02h colmod=%02h want 1/48/55", inv_on, madctl, colmod);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_PARAM) $display("FAIL state_param got %0d want 2", dbg_state);
    else n_pass++;
    send_byte(1'b0, 8'h10); exp_q.push_back({1'b0, 8'h10});
    send_byte(1'b0, 8'h28); exp_q.push_back({1'b0, 8'h28});
    send_byte(1'b0, 8'h20); exp_q.push_back({1'b0, 8'h20});
    send_byte(1'b0, 8'h55); exp_q.push_back({1'b0, 8'h55});
    wait_clks(6);
    n_checks++;
    if ({sleep_out, display_on, inv_on, madctl, colmod} !== {3'b000, 8'h48, 8'h55})
      $display("FAIL clear_flags got %b %02h %02h want 000 48 55",
               {sleep_out, display_on, inv_on}, madctl, colmod);
    else n_pass++;
    cs_high();
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      n_checks++;
      if (got_bytes.size() == 0) $display("FAIL cmd_byte got none want %03h", exp_b);
      else begin
        got_b = got_bytes.pop_front();
        if (got_b !== exp_b) $display("FAIL cmd_byte got %03h want %03h", got_b, exp_b);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_bytes.size() != 0) $display("FAIL cmd_extra_bytes got %0d want 0", got_bytes.size());
    else n_pass++;
  endtask

  task automatic test_window();
    logic [48:0] exp_p;
    logic [48:0] got_p;
    clear_obs();
    cs_low();
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h28); send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h17);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h35); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h37);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b1, 8'hF8);
      send_byte(1'b1, 8'h00);
      exp_pix.push_back({1'b0, 16'h0028 + 16'(i), 16'h0035, 16'hF800});
    end
    wait_clks(6);
    cs_high();
    n_checks++;
    if (got_pix.size() != 6) $display("FAIL window_pix_count got %0d want 6", got_pix.size());
    else n_pass++;
    while (exp_pix.size() > 0 && got_pix.size() > 0) begin
      exp_p = exp_pix.pop_front();
      got_p = got_pix.pop_front();
      n_checks++;
      if (got_p !== exp_p) $display("FAIL window_pixel got %013h want %013h", got_p, exp_p);
      else n_pass++;
    end
  endtask

  task automatic test_frame_wrap();
    logic [48:0] exp_p;
    logic [48:0] got_p;
    clear_obs();
    cs_low();
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, 8'h10);
      send_byte(1'b1, 8'(8'hA0 + i));
    end
    exp_pix.push_back({1'b0, 16'd0, 16'd0, 16'h10A0});
    exp_pix.push_back({1'b0, 16'd1, 16'd0, 16'h10A1});
    exp_pix.push_back({1'b0, 16'd0, 16'd1, 16'h10A2});
    exp_pix.push_back({1'b1, 16'd1, 16'd1, 16'h10A3});
    exp_pix.push_back({1'b0, 16'd0, 16'd0, 16'h10A4});
    wait_clks(6);
    cs_high();
    n_checks++;
    if (got_pix.size() != 5) $display("FAIL wrap_pix_count got %0d want 5", got_pix.size());
    else n_pass++;
    while (exp_pix.size() > 0 && got_pix.size() > 0) begin
      exp_p = exp_pix.pop_front();
      got_p = got_pix.pop_front();
      n_checks++;
      if (got_p !== exp_p) $display("FAIL wrap_pixel got %013h want %013h", got_p, exp_p);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    clear_obs();
    cs_low();
    send_bits(1'b0, 8'hA5, 5);
    cs_high();
    n_checks++;
    if (abort_cnt != 1) $display("FAIL abort_pulse got %0d want 1", abort_cnt);
    else n_pass++;
    n_checks++;
    if (got_bytes.size() != 0) $display("FAIL abort_no_byte got %0d want 0", got_bytes.size());
    else n_pass++;
    cs_low();
    send_byte(1'b0, 8'h21);
    wait_clks(6);
    cs_high();
    n_checks++;
    if (got_bytes.size() != 1) $display("FAIL after_abort_count got %0d want 1", got_bytes.size());
    else if (got_bytes[0] !== {1'b0, 8'h21})
      $display("FAIL after_abort_byte got %03h want 021", got_bytes[0]);
    else n_pass++;
    n_checks++;
    if (inv_on !== 1'b1 || abort_cnt != 1)
      $display("FAIL after_abort_decode got inv=%b aborts=%0d want 1/1", inv_on, abort_cnt);
    else n_pass++;
  endtask

  task automatic test_dropped_byte();
    clear_obs();
    cs_low();
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h09);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD); send_byte(1'b1, 8'hEF);
    send_byte(1'b0, 8'h2A);
    wait_clks(6);
    n_checks++;
    if (got_pix.size() != 1) $display("FAIL drop_pix_count got %0d want 1", got_pix.size());
    else if (got_pix[0] !== {1'b0, 16'd5, 16'd0, 16'hABCD})
      $display("FAIL drop_pixel got %013h want %013h", got_pix[0], {1'b0, 16'd5, 16'd0, 16'hABCD});
    else n_pass++;
    n_checks++;
    if (pixel_x !== 16'd5 || dbg_state !== ST_PARAM)
      $display("FAIL drop_hold got x=%04h state=%0d want 0005/2", pixel_x, dbg_state);
    else n_pass++;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
    wait_clks(6);
    cs_high();
    n_checks++;
    if (got_pix.size() != 2) $display("FAIL drop_next_count got %0d want 2", got_pix.size());
    else if (got_pix[1] !== {1'b0, 16'd5, 16'd0, 16'h1234})
      $display("FAIL drop_next_pixel got %013h want %013h", got_pix[1], {1'b0, 16'd5, 16'd0, 16'h1234});
    else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    clear_obs();
    cs_low();
    send_byte(1'b0, 8'h3A);
    send_byte(1'b1, 8'h77);
    wait_clks(6);
    n_checks++;
    if (colmod !== 8'h77) $display("FAIL colmod_set got %02h want 77", colmod);
    else n_pass++;
    send_bits(1'b1, 8'hFF, 3);
    reset  = 1'b1;
    lcd_cs = 1'b1;
    wait_clks(3);
    reset  = 1'b0;
    wait_clks(10);
    n_checks++;
    if (abort_cnt != 0 || colmod !== 8'h66 || madctl !== 8'h00)
      $display("FAIL reset_mid_byte got aborts=%0d colmod=%02h madctl=%02h want 0/66/00",
               abort_cnt, colmod, madctl);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_commands();
    test_window();
    test_frame_wrap();
    test_abort();
    test_dropped_byte();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
